// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and word-width limits shared by the UART RX and TX sequencers
package uart_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_START = 3'd1;
  localparam state_t S_DATA  = 3'd2;
  localparam state_t S_PAR   = 3'd3;
  localparam state_t S_STOP  = 3'd4;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
endpackage

// File: rtl/uart_rx_sequencer_if.sv
// uart_rx_sequencer_if: sampling-timer control and host-side valid/ready word port (parity_err only with UART_RX_PARITY_EN)
interface uart_rx_sequencer_if #(parameter int DATA_BITS = 8);
  logic                 timer_start;
  logic                 timer_sample;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
  modport master(output timer_start, rx_data, rx_valid, frame_err, overrun, busy, parity_err,
                 input timer_sample, rx_ready);
  modport slave(input timer_start, rx_data, rx_valid, frame_err, overrun, busy, parity_err,
                output timer_sample, rx_ready);
`else
  modport master(output timer_start, rx_data, rx_valid, frame_err, overrun, busy,
                 input timer_sample, rx_ready);
  modport slave(input timer_start, rx_data, rx_valid, frame_err, overrun, busy,
                output timer_sample, rx_ready);
`endif
endinterface

// File: rtl/uart_rx_sequencer_rx_sync.sv
// rx_sync: 2-FF synchroniser that resets to 1 so an idle-high line sees no false edge out of reset
module rx_sync #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta, r_sync;
  // two-stage resynchronisation of the asynchronous input
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  assign o_q = r_sync;
endmodule

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: UART receive FSM driving the sampling timer; even parity with UART_RX_PARITY_EN
module uart_rx_sequencer
  import uart_pkg::*;
#(parameter int DATA_BITS = 8) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  uart_rx_sequencer_if.master   bus
);
  localparam int CW = $clog2(DATA_BITS + 1);
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_bits
    $error("uart_rx_sequencer: DATA_BITS out of range");
  end
  logic                 w_rxd_sync, w_fall, w_start, w_sample, w_last;
  logic                 w_stop_smp, w_done, w_ferr, w_accept, w_busy;
  logic                 r_rxd_prev;
  state_t               r_state, w_next;
  logic [DATA_BITS-1:0] r_shreg, r_rx_data;
  logic [CW-1:0]        r_bit_cnt;
  logic                 r_rx_valid, r_frame_err, r_overrun;
  rx_sync #(.W(1)) u_sync (.clk(clk), .rst(rst), .i_d(rxd), .o_q(w_rxd_sync));
  assign w_fall     = r_rxd_prev & ~w_rxd_sync;
  assign w_sample   = bus.timer_sample & (r_state != S_IDLE);
  assign w_last     = r_bit_cnt == CW'(DATA_BITS - 1);
  assign w_stop_smp = (r_state == S_STOP) & w_sample;
  assign w_done     = w_stop_smp & w_rxd_sync;
  assign w_ferr     = w_stop_smp & ~w_rxd_sync;
  assign w_accept   = r_rx_valid & bus.rx_ready;
  // edge-detect delay flop and FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rxd_prev <= 1'b1;
      r_state    <= S_IDLE;
    end else begin
      r_rxd_prev <= w_rxd_sync;
      r_state    <= w_next;
    end
  // next state: each non-idle state advances only on a timer sample
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_fall ? S_START : S_IDLE;
      S_START: w_next = w_sample ? (w_rxd_sync ? S_IDLE : S_DATA) : S_START;
`ifdef UART_RX_PARITY_EN
      S_DATA:  w_next = (w_sample && w_last) ? S_PAR : S_DATA;
      S_PAR:   w_next = w_sample ? S_STOP : S_PAR;
`else
      S_DATA:  w_next = (w_sample && w_last) ? S_STOP : S_DATA;
`endif
      S_STOP:  w_next = w_sample ? S_IDLE : S_STOP;
      default: w_next = S_IDLE;
    endcase
  end
  // FSM outputs: timer restart on a start edge seen in IDLE, busy outside IDLE
  always_comb begin
    w_start = (r_state == S_IDLE) & w_fall;
    w_busy  = r_state != S_IDLE;
  end
  // LSB-first shift register; bit counter cleared on entry to DATA
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == S_START && w_sample) begin
      r_bit_cnt <= '0;
    end else if (r_state == S_DATA && w_sample) begin
      r_shreg   <= {w_rxd_sync, r_shreg[DATA_BITS-1:1]};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  // holding register: a completion loads only if the slot is free or being accepted this cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_accept ? 1'b0 : (r_overrun | (w_done & r_rx_valid));
      if (w_done && (!r_rx_valid || w_accept)) begin
        r_rx_data  <= r_shreg;
        r_rx_valid <= 1'b1;
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_parity_err;
  // latch the parity verdict in PAR and report it alongside the stop sample
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bad    <= (r_state == S_PAR && w_sample) ? (w_rxd_sync ^ (^r_shreg)) : r_par_bad;
      r_parity_err <= w_stop_smp & r_par_bad;
    end
  assign bus.parity_err = r_parity_err;
`endif
  assign bus.timer_start = w_start;
  assign bus.busy        = w_busy;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb_uart_rx_sequencer: directed frames through the RX sequencer paired with a bit_time=16 sampling timer
module tb_uart_rx_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  int checks = 0;
  int failures = 0;
  int ferr_c = 0, ts_c = 0, busy_c = 0, hi_c = 0, rise_c = 0, perr_c = 0;
  logic pv = 1'b0;
  logic [3:0] tcnt;

  uart_rx_sequencer_if #(.DATA_BITS(8)) bus();
  uart_rx_sequencer #(.DATA_BITS(8)) dut (.clk(clk), .rst(rst), .rxd(rxd), .bus(bus));

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= 4'd15;
    else tcnt <= bus.timer_start ? 4'd7 : (tcnt == 4'd0 ? 4'd15 : tcnt - 4'd1);
  assign bus.timer_sample = (tcnt == 4'd0);

  always @(negedge clk) begin
    ferr_c += int'(bus.frame_err);
    ts_c   += int'(bus.timer_start);
    busy_c += int'(bus.busy);
    hi_c   += int'(bus.rx_valid);
    if (bus.rx_valid && !pv) rise_c++;
    pv = bus.rx_valid;
`ifdef UART_RX_PARITY_EN
    perr_c += int'(bus.parity_err);
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    repeat (16) @(negedge clk);
`endif
    rxd = stop;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       rdy;
    int         rises;
    int         ferr;
    logic [7:0] data;
    logic       ov;
    logic       vend;
  } vec_t;

  initial begin
    vec_t v[5];
    int b_f, b_r, b_h, b_p, b_t, b_b;
    v[0] = '{8'hA5, 1'b1, 1'b1, 1, 0, 8'hA5, 1'b0, 1'b0};
    v[1] = '{8'h3C, 1'b0, 1'b1, 0, 1, 8'hA5, 1'b0, 1'b0};
    v[2] = '{8'h55, 1'b1, 1'b1, 1, 0, 8'h55, 1'b0, 1'b0};
    v[3] = '{8'h11, 1'b1, 1'b0, 1, 0, 8'h11, 1'b0, 1'b1};
    v[4] = '{8'h22, 1'b1, 1'b0, 0, 0, 8'h11, 1'b1, 1'b1};
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(bus.rx_data), 0);
    chk("rst_valid", 32'(bus.rx_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);
    chk("rst_tstart", 32'(bus.timer_start), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      bus.rx_ready = v[i].rdy;
      b_f = ferr_c; b_r = rise_c; b_h = hi_c; b_p = perr_c;
      send_frame(v[i].d, ^v[i].d, v[i].stop);
      repeat (24) @(negedge clk);
      chk($sformatf("v%0d_rises", i), 32'(rise_c - b_r), 32'(v[i].rises));
      chk($sformatf("v%0d_ferr", i), 32'(ferr_c - b_f), 32'(v[i].ferr));
      chk($sformatf("v%0d_data", i), 32'(bus.rx_data), 32'(v[i].data));
      chk($sformatf("v%0d_ovr", i), 32'(bus.overrun), 32'(v[i].ov));
      chk($sformatf("v%0d_valid", i), 32'(bus.rx_valid), 32'(v[i].vend));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 0);
      chk($sformatf("v%0d_perr", i), 32'(perr_c - b_p), 0);
      if (v[i].rdy) chk($sformatf("v%0d_highs", i), 32'(hi_c - b_h), 32'(v[i].rises));
    end

    bus.rx_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid", 32'(bus.rx_valid), 0);
    chk("accept_ovr", 32'(bus.overrun), 0);
    chk("accept_data", 32'(bus.rx_data), 32'h11);

    b_t = ts_c; b_r = rise_c; b_b = busy_c;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_tstart", 32'(ts_c - b_t), 1);
    chk("glitch_busy_seen", 32'(busy_c > b_b), 1);
    chk("glitch_busy_end", 32'(bus.busy), 0);
    chk("glitch_rises", 32'(rise_c - b_r), 0);

`ifdef UART_RX_PARITY_EN
    b_p = perr_c; b_r = rise_c;
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (24) @(negedge clk);
    chk("par_bad_perr", 32'(perr_c - b_p), 1);
    chk("par_bad_data", 32'(bus.rx_data), 32'h01);
    chk("par_bad_rises", 32'(rise_c - b_r), 1);
    b_p = perr_c;
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (24) @(negedge clk);
    chk("par_ok_perr", 32'(perr_c - b_p), 0);
`endif

    fork
      send_frame(8'hF0, 1'b0, 1'b1);
      begin
        int k = 0;
        int n = 0;
        while (!bus.timer_start && k < 100) begin
          @(negedge clk);
          k++;
        end
        while (n < 5 && k < 400) begin
          @(negedge clk);
          k++;
          if (bus.timer_sample) n++;
        end
        chk("rst_wait_bit3", 32'(n), 5);
        #1 rst = 1'b1;
        #1;
        chk("midrst_data", 32'(bus.rx_data), 0);
        chk("midrst_valid", 32'(bus.rx_valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_ovr", 32'(bus.overrun), 0);
        chk("midrst_ferr", 32'(bus.frame_err), 0);
        chk("midrst_tstart", 32'(bus.timer_start), 0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
      end
    join
    b_r = rise_c;
    repeat (24) @(negedge clk);
    chk("postrst_rises", 32'(rise_c - b_r), 0);
    chk("postrst_busy", 32'(bus.busy), 0);
    b_r = rise_c; b_f = ferr_c;
    send_frame(8'h7E, ^8'h7E, 1'b1);
    repeat (24) @(negedge clk);
    chk("post_7e_data", 32'(bus.rx_data), 32'h7E);
    chk("post_7e_rises", 32'(rise_c - b_r), 1);
    chk("post_7e_ferr", 32'(ferr_c - b_f), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
